// File: rtl/banco_pkg.sv
// Shared types, default sizes and helpers for the banco_param register bank.
// Optional build macro BANCO_BYPASS_EN (used by banco_param) enables
// write-to-read forwarding; this package does not depend on it.
package banco_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } banco_state_t;

  // True when addr names a real entry of a bank holding depth registers.
  function automatic logic addr_valid(input logic [31:0] addr, input int unsigned depth);
    return (addr < depth);
  endfunction

endpackage

// File: rtl/banco_clear_seq.sv
// Post-reset clear sequencer for banco_param: walks every entry once,
// asking the array to write zero, and holds busy high until it is done.
// Not affected by BANCO_BYPASS_EN.
module banco_clear_seq
  import banco_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  banco_state_t      state;
  logic [ADDR_W-1:0] ptr;

  // Clear FSM: one entry per cycle from 0 to DEPTH-1, then park in READY.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= CLEAR;
      ptr   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          if (ptr == LAST_ADDR) begin
            state <= READY;
            ptr   <= '0;
            busy  <= 1'b0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        READY: begin
          state <= READY;
          busy  <= 1'b0;
        end
        default: begin
          state <= CLEAR;
          ptr   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  assign clr_we   = (state == CLEAR);
  assign clr_addr = ptr;

endmodule

// File: rtl/banco_param.sv
// Parametrised register bank: one synchronous write port, two registered
// read ports, hardware clear after reset and optional hardwired zero register.
// Build macro BANCO_BYPASS_EN: when defined, a same-cycle write to the address
// being read is forwarded to that read port; otherwise the read sees the old
// value. Dropped writes are never forwarded.
module banco_param
  import banco_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid,
  output logic              busy
);

  localparam logic HAS_ZERO = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_ok;
  logic              rd_go;
  logic [DATA_W-1:0] rd_word_a;
  logic [DATA_W-1:0] rd_word_b;

  banco_clear_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clock    (clock),
    .reset    (reset),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Decide whether this cycle's user write really lands in the array.
  always_comb begin
    wr_ok = wr_en && !busy
            && addr_valid(32'(wr_addr), DEPTH)
            && !(HAS_ZERO && (wr_addr == '0));
    rd_go = rd_en && !busy;
  end

  // Pick the word each read port will capture, including forwarding if built in.
  always_comb begin
    rd_word_a = '0;
    rd_word_b = '0;
    if (addr_valid(32'(rd_addr_a), DEPTH) && !(HAS_ZERO && (rd_addr_a == '0))) begin
      rd_word_a = mem[rd_addr_a];
    end
    if (addr_valid(32'(rd_addr_b), DEPTH) && !(HAS_ZERO && (rd_addr_b == '0))) begin
      rd_word_b = mem[rd_addr_b];
    end
`ifdef BANCO_BYPASS_EN
    if (wr_ok && (wr_addr == rd_addr_a)) begin
      rd_word_a = wr_data;
    end
    if (wr_ok && (wr_addr == rd_addr_b)) begin
      rd_word_b = wr_data;
    end
`endif
  end

  // Array write port: the clear sequencer owns it while busy, the user after.
  always_ff @(posedge clock) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read data and one-cycle valid strobe; data holds when idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= rd_go;
      if (rd_go) begin
        rd_data_a <= rd_word_a;
        rd_data_b <= rd_word_b;
      end
    end
  end

endmodule

// File: tb/tb_banco_param.sv
// Scoreboard bench for banco_param: two instances (DEPTH 32 with zero
// register, DEPTH 24 without) share one stimulus stream and each is checked
// against an array-based model of the register bank.
module tb_banco_param;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        rd_en = 1'b0;
  logic [4:0]  rd_addr_a = '0;
  logic [4:0]  rd_addr_b = '0;

  logic [31:0] rd_data_a0, rd_data_b0, rd_data_a1, rd_data_b1;
  logic        rd_valid0, rd_valid1, busy0, busy1;

  logic [31:0] mdl_mem [2][32];
  int          since [2];
  logic [31:0] last_a [2];
  logic [31:0] last_b [2];
  exp_t        q0[$];
  exp_t        q1[$];

  int checks = 0;
  int passed = 0;

  always #5 clock = ~clock;

  banco_param #(.DATA_W(32), .DEPTH(32), .ZERO_REG(1)) dut0 (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a0), .rd_data_b(rd_data_b0),
    .rd_valid(rd_valid0), .busy(busy0)
  );

  banco_param #(.DATA_W(32), .DEPTH(24), .ZERO_REG(0)) dut1 (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a1), .rd_data_b(rd_data_b1),
    .rd_valid(rd_valid1), .busy(busy1)
  );

  function automatic int dep(input int k);
    return (k == 0) ? 32 : 24;
  endfunction

  function automatic bit zr(input int k);
    return (k == 0);
  endfunction

  function automatic logic [31:0] mdlRead(input int k, input logic [4:0] a);
    if (int'(a) >= dep(k) || (zr(k) && a == 5'd0)) return 32'h0;
    return mdl_mem[k][a];
  endfunction

  function automatic bit mdlWrOk(input int k, input logic we, input logic [4:0] a);
    return we && (int'(a) < dep(k)) && !(zr(k) && a == 5'd0);
  endfunction

  // Advance the reference model by one rising edge using the current inputs.
  task automatic modelStep();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        since[k]  = 0;
        last_a[k] = 32'h0;
        last_b[k] = 32'h0;
        if (k == 0) q0.delete(); else q1.delete();
      end else if (since[k] < dep(k)) begin
        since[k]++;
        if (since[k] == dep(k)) begin
          for (int i = 0; i < 32; i++) mdl_mem[k][i] = 32'h0;
        end
      end else begin
        if (rd_en) begin
          e.a = mdlRead(k, rd_addr_a);
          e.b = mdlRead(k, rd_addr_b);
`ifdef BANCO_BYPASS_EN
          if (mdlWrOk(k, wr_en, wr_addr) && wr_addr == rd_addr_a) e.a = wr_data;
          if (mdlWrOk(k, wr_en, wr_addr) && wr_addr == rd_addr_b) e.b = wr_data;
`endif
          if (k == 0) q0.push_back(e); else q1.push_back(e);
        end
        if (mdlWrOk(k, wr_en, wr_addr)) mdl_mem[k][wr_addr] = wr_data;
      end
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then step the model.
  task automatic applyStimulus(input logic rst, input logic we, input logic [4:0] wa,
                               input logic [31:0] wd, input logic re,
                               input logic [4:0] ra, input logic [4:0] rb);
    @(negedge clock);
    reset     = rst;
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    rd_en     = re;
    rd_addr_a = ra;
    rd_addr_b = rb;
    @(posedge clock);
    modelStep();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
  endtask

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Compare one instance's outputs with the scoreboard after an edge.
  task automatic checkOutput(input int k, input logic v, input logic [31:0] a,
                             input logic [31:0] b, input logic bz);
    exp_t e;
    bit   have;
    bit   exp_busy;
    exp_busy = reset || (since[k] < dep(k));
    have     = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
    checkEq($sformatf("busy%0d", k), {31'h0, bz}, {31'h0, exp_busy});
    checkEq($sformatf("rd_valid%0d", k), {31'h0, v}, {31'h0, have});
    if (have) begin
      e = (k == 0) ? q0.pop_front() : q1.pop_front();
      last_a[k] = e.a;
      last_b[k] = e.b;
    end
    checkEq($sformatf("rd_data_a%0d", k), a, last_a[k]);
    checkEq($sformatf("rd_data_b%0d", k), b, last_b[k]);
  endtask

  // Monitor: sample both instances just after every rising edge.
  always @(posedge clock) begin
    #1;
    checkOutput(0, rd_valid0, rd_data_a0, rd_data_b0, busy0);
    checkOutput(1, rd_valid1, rd_data_a1, rd_data_b1, busy1);
  end

  initial begin
    since[0] = 0;
    since[1] = 0;
    for (int k = 0; k < 2; k++) begin
      last_a[k] = 32'h0;
      last_b[k] = 32'h0;
    end
    reset = 1'b0;
    #1;
    reset = 1'b1;
    $display("[TB] reset and clear sequence");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    idle(34);
    for (int i = 0; i < 32; i++) applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 5'(31 - i));

    $display("[TB] prefill then reset mid-clear");
    for (int i = 1; i < 32; i++)
      applyStimulus(1'b0, 1'b1, 5'(i), (i * 32'h01010101) ^ 32'h5A, 1'b0, 5'd0, 5'd0);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    idle(10);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    for (int i = 0; i < 20; i++)
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    idle(14);
    for (int i = 0; i < 32; i++) applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 5'(i));

    $display("[TB] directed reads and writes");
    applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd0);
    applyStimulus(1'b0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 5'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0);
    applyStimulus(1'b0, 1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 5'd0);
    applyStimulus(1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b1, 5'd7, 5'd7);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7);
    applyStimulus(1'b0, 1'b1, 5'd30, 32'hFFFF, 1'b0, 5'd0, 5'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd30, 5'd23);
    applyStimulus(1'b0, 1'b1, 5'd3, 32'hCAFE, 1'b0, 5'd0, 5'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd7);
    idle(3);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      logic [4:0] wa;
      logic [4:0] ra;
      logic [4:0] rb;
      wa = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      ra = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 2) == 0) ? ra : 5'($urandom_range(0, 7));
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), wa, $urandom,
                    1'($urandom_range(0, 2) != 0), ra, rb);
    end
    idle(2);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
